pipe_controller: RTL and testbench
==================================

// Module: pipe_controller
// PURPOSE
//  Control unit for the 5-stage RV32I pipeline (F/D/E/M/W). Decodes opD/funct3D/funct7b5D and pipes control D->E->M->W.
//  Adds over the previous controller:
//  - full branch set (beq/bne/blt/bge/bltu/bgeu) and jalr
//  - E-stage stall
//  - per-stage valid tracking
//  - load/store size to M
//  - a retired-instruction counter
//  Sits between datapath and hazard unit.
// PARAMETERS
//  CNT_W        32  width of RetireCount; wraps modulo 2**CNT_W
//  FULL_BRANCH  1   1: all six branch conditions; 0: every branch funct3 evaluates as beq
// PORTS
//  clk           in   1  clock; all state on rising edge
//  reset         in   1  asynchronous, active-low reset (0 = reset asserted)
//  opD           in   7  opcode, D stage
//  funct3D       in   3  funct3, D stage
//  funct7b5D     in   1  instr[30], D stage
//  ValidD        in   1  D holds a real instruction (0 = bubble)
//  StallE        in   1  hold E register (hazard unit)
//  FlushE        in   1  clear E register to bubble (hazard unit)
//  ZeroE         in   1  ALU result == 0
//  NegE          in   1  ALU result sign bit (rs1-rs2)
//  OvfE          in   1  signed overflow of rs1-rs2
//  CarryE        in   1  carry-out of rs1+~rs2+1 (1 = rs1 >=u rs2)
//  ImmSrcD       out  3  immediate select, D (combinational)
//  PCSrcE        out  1  take branch/jump
//  JalrE         out  1  PC target = ALU result (jalr), else PC+imm
//  ALUControlE   out  4  ALU op (alu_ops_pkg encoding)
//  ALUSrcAE      out  1  ALU A select
//  ALUSrcBE      out  1  ALU B select
//  ResultSrcEb0  out  1  E instr is a load (hazard unit)
//  MemWriteM     out  1  store enable
//  MemSizeM      out  3  funct3 of load/store in M (size/sign)
//  RegWriteM     out  1  reg write, M
//  RegWriteW     out  1  reg write, W
//  ResultSrcW    out  2  result mux select, W
//  RetireCount   out  CNT_W  instructions retired from W
// BEHAVIOUR
//  - Reset (reset=0, async): all E/M/W registers, valid bits and RetireCount = 0.
//    All registered outputs therefore read 0; ALUControlE=ADD(0).
//  - Decode (combinational), new vs prior decoder:
//    - jalr (1100111): RegWrite=1, ResultSrc=10, ALUSrcB=imm, ImmSrc=I, Jump=1, Jalr=1.
//    - sll/srl/sra/sltu and immediate forms get distinct 4-bit ALU codes.
//    - Branches force ALUControl=SUB.
//    - Undefined opcode: all write/jump/branch enables 0, ALUControl=ADD.
//  - E register {RegWrite,ResultSrc,MemWrite,Jump,Jalr,Branch,funct3,ALUControl,ALUSrcA,ALUSrcB,Valid}:
//    - FlushE=1: load zeros (bubble). FlushE wins over StallE.
//    - else StallE=1: hold.
//    - else: load D values.
//  - Control gating: D-stage enables are ANDed with ValidD before entering E.
//  - M and W registers load every cycle (no stall/flush). When StallE=1, M receives a bubble (zeros), not a duplicate of E.
//  - Branch evaluation, taken = Branch & cond(funct3E):
//    - 000: ZeroE; 001: !ZeroE
//    - 100: NegE^OvfE; 101: !(NegE^OvfE)
//    - 110: !CarryE; 111: CarryE
//    - 010/011: never taken
//    - FULL_BRANCH=0: cond = ZeroE for all funct3
//  - PCSrcE = taken | JumpE; JalrE = JumpE & JalrFlag.
//  - Latency: D->E 1 cycle, E->M 1, M->W 1.
//  - RetireCount: +1 on each rising edge with ValidW=1; wraps to 0 at 2**CNT_W-1.
// STRUCTURE
//  - alu_ops_pkg: ALU op enum (4-bit), opcode localparams, ImmSrc encodings, branch funct3 constants.
//  - Sub-module: pipe_maindec (opcode/funct -> D-stage control bundle, purely combinational).
//  - Branch compare, pipeline regs and counter live inline.
// TESTING
//  1. Hold reset=0 mid-stream with instructions in flight:
//     - all outputs 0 within the same cycle, before the next clk edge
//     - RetireCount=0 after release
//  2. blt with NegE=1,OvfE=0 -> PCSrcE=1.
//     - bltu with CarryE=1 -> PCSrcE=0.
//     - bge with NegE=1,OvfE=1 -> PCSrcE=1.
//     - FULL_BRANCH=0, blt with ZeroE=0 -> PCSrcE=0.
//  3. jalr in D -> next cycle PCSrcE=1, JalrE=1.
//     - 3 cycles later RegWriteW=1, ResultSrcW=2'b10.
//  4. lw in E with StallE=1 for 2 cycles:
//     - E outputs held (ResultSrcEb0=1)
//     - M shows bubbles
//     - then lw reaches M with MemSizeM=3'b010
//  5. FlushE=1 and StallE=1 same cycle -> E cleared, PCSrcE=0.
//     - the flushed instr never raises RegWriteW.
//  6. CNT_W=4, 17 back-to-back valid addi -> RetireCount = 1 after the 17th retires (wrap at 15->0).
//     - ValidD=0 cycles do not increment.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Shared encodings for the pipeline controller: ALU ops, opcodes, immediate
// selects, branch funct3 values and the E-stage control bundle.
package alu_ops_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       jalr;
      logic       branch;
      logic [2:0] funct3;
      alu_op_e    alu_ctrl;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       valid;
   } ctrl_e_t;

   // Subtraction only exists for R-type; addi with instr[30] set stays an add.
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                          input logic is_r);
      alu_op_e r;
      r = ALU_ADD;
      case (f3)
         3'b000: r = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001: r = ALU_SLL;
         3'b010: r = ALU_SLT;
         3'b011: r = ALU_SLTU;
         3'b100: r = ALU_XOR;
         3'b101: r = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110: r = ALU_OR;
         3'b111: r = ALU_AND;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Controller <-> datapath/hazard-unit bundle. The controller is the master;
// no valid/ready handshake: ValidD only marks D as a real instruction vs bubble.
interface pipe_controller_if #(parameter int CNT_W = 32);
   logic [6:0]       opD;
   logic [2:0]       funct3D;
   logic             funct7b5D;
   logic             ValidD;
   logic             StallE;
   logic             FlushE;
   logic             ZeroE;
   logic             NegE;
   logic             OvfE;
   logic             CarryE;
   logic [2:0]       ImmSrcD;
   logic             PCSrcE;
   logic             JalrE;
   logic [3:0]       ALUControlE;
   logic             ALUSrcAE;
   logic             ALUSrcBE;
   logic             ResultSrcEb0;
   logic             MemWriteM;
   logic [2:0]       MemSizeM;
   logic             RegWriteM;
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;
   logic [CNT_W-1:0] RetireCount;

   modport master (
      input  opD, funct3D, funct7b5D, ValidD, StallE, FlushE,
             ZeroE, NegE, OvfE, CarryE,
      output ImmSrcD, PCSrcE, JalrE, ALUControlE, ALUSrcAE, ALUSrcBE,
             ResultSrcEb0, MemWriteM, MemSizeM, RegWriteM, RegWriteW,
             ResultSrcW, RetireCount
   );

   modport slave (
      output opD, funct3D, funct7b5D, ValidD, StallE, FlushE,
             ZeroE, NegE, OvfE, CarryE,
      input  ImmSrcD, PCSrcE, JalrE, ALUControlE, ALUSrcAE, ALUSrcBE,
             ResultSrcEb0, MemWriteM, MemSizeM, RegWriteM, RegWriteW,
             ResultSrcW, RetireCount
   );
endinterface

// File: rtl/pipe_maindec.sv
// Purely combinational D-stage decoder: opcode/funct3/funct7b5 to the
// immediate select and the control bundle that is registered into E.
module pipe_maindec
   import alu_ops_pkg::*;
(
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output logic [2:0] o_imm_src,
   output ctrl_e_t    o_ctrl
);

   always_comb begin
      o_imm_src       = IMM_I;
      o_ctrl          = '0;
      o_ctrl.funct3   = i_funct3;
      o_ctrl.alu_ctrl = ALU_ADD;
      case (i_op)
         OP_LOAD: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.result_src = 2'b01;
            o_ctrl.alu_src_b  = 1'b1;
         end
         OP_STORE: begin
            o_imm_src        = IMM_S;
            o_ctrl.mem_write = 1'b1;
            o_ctrl.alu_src_b = 1'b1;
         end
         OP_RTYPE: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_ctrl  = alu_decode(i_funct3, i_funct7b5, 1'b1);
         end
         OP_ITYPE: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src_b = 1'b1;
            o_ctrl.alu_ctrl  = alu_decode(i_funct3, i_funct7b5, 1'b0);
         end
         OP_BRANCH: begin
            o_imm_src       = IMM_B;
            o_ctrl.branch   = 1'b1;
            o_ctrl.alu_ctrl = ALU_SUB;
         end
         OP_JAL: begin
            o_imm_src         = IMM_J;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.result_src = 2'b10;
            o_ctrl.jump       = 1'b1;
         end
         OP_JALR: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.result_src = 2'b10;
            o_ctrl.alu_src_b  = 1'b1;
            o_ctrl.jump       = 1'b1;
            o_ctrl.jalr       = 1'b1;
         end
         OP_LUI: begin
            o_imm_src         = IMM_U;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.result_src = 2'b11;
         end
         OP_AUIPC: begin
            o_imm_src        = IMM_U;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_controller.sv
// RV32I 5-stage pipeline control: decode in D, carry control through E/M/W,
// resolve branches/jumps in E and count retired instructions.
module pipe_controller #(
   parameter int CNT_W       = 32,
   parameter bit FULL_BRANCH = 1'b1
) (
   input logic               clk,
   input logic               reset,
   pipe_controller_if.master bus
);
   import alu_ops_pkg::*;

   logic [2:0]       w_imm_src;
   ctrl_e_t          w_dec;
   ctrl_e_t          w_e_next;
   ctrl_e_t          r_e;
   logic             w_cond;
   logic             r_m_reg_write;
   logic [1:0]       r_m_result_src;
   logic             r_m_mem_write;
   logic [2:0]       r_m_mem_size;
   logic             r_m_valid;
   logic             r_w_reg_write;
   logic [1:0]       r_w_result_src;
   logic             r_w_valid;
   logic [CNT_W-1:0] r_retire;

   pipe_maindec u_maindec (
      .i_op       (bus.opD),
      .i_funct3   (bus.funct3D),
      .i_funct7b5 (bus.funct7b5D),
      .o_imm_src  (w_imm_src),
      .o_ctrl     (w_dec)
   );

   // A bubble in D must not write, store, jump or branch once it reaches E.
   always_comb begin
      w_e_next           = w_dec;
      w_e_next.reg_write = w_dec.reg_write & bus.ValidD;
      w_e_next.mem_write = w_dec.mem_write & bus.ValidD;
      w_e_next.jump      = w_dec.jump      & bus.ValidD;
      w_e_next.branch    = w_dec.branch    & bus.ValidD;
      w_e_next.valid     = bus.ValidD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_e <= '0;
      else if (bus.FlushE)   r_e <= '0;
      else if (!bus.StallE)  r_e <= w_e_next;
   end

   always_comb begin
      w_cond = 1'b0;
      if (!FULL_BRANCH) begin
         w_cond = bus.ZeroE;
      end else begin
         case (r_e.funct3)
            F3_BEQ:  w_cond = bus.ZeroE;
            F3_BNE:  w_cond = ~bus.ZeroE;
            F3_BLT:  w_cond = bus.NegE ^ bus.OvfE;
            F3_BGE:  w_cond = ~(bus.NegE ^ bus.OvfE);
            F3_BLTU: w_cond = ~bus.CarryE;
            F3_BGEU: w_cond = bus.CarryE;
            default: w_cond = 1'b0;
         endcase
      end
   end

   // A stalled E instruction stays put, so M must see a bubble, not a copy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || bus.StallE) begin
         r_m_reg_write  <= 1'b0;
         r_m_result_src <= 2'b00;
         r_m_mem_write  <= 1'b0;
         r_m_mem_size   <= 3'b000;
         r_m_valid      <= 1'b0;
      end else begin
         r_m_reg_write  <= r_e.reg_write;
         r_m_result_src <= r_e.result_src;
         r_m_mem_write  <= r_e.mem_write;
         r_m_mem_size   <= (r_e.valid & (r_e.mem_write | (r_e.result_src == 2'b01)))
                           ? r_e.funct3 : 3'b000;
         r_m_valid      <= r_e.valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_w_reg_write  <= 1'b0;
         r_w_result_src <= 2'b00;
         r_w_valid      <= 1'b0;
         r_retire       <= '0;
      end else begin
         r_w_reg_write  <= r_m_reg_write;
         r_w_result_src <= r_m_result_src;
         r_w_valid      <= r_m_valid;
         if (r_w_valid) r_retire <= r_retire + CNT_W'(1);
      end
   end

   assign bus.ImmSrcD      = w_imm_src;
   assign bus.PCSrcE       = (r_e.branch & w_cond) | r_e.jump;
   assign bus.JalrE        = r_e.jump & r_e.jalr;
   assign bus.ALUControlE  = r_e.alu_ctrl;
   assign bus.ALUSrcAE     = r_e.alu_src_a;
   assign bus.ALUSrcBE     = r_e.alu_src_b;
   assign bus.ResultSrcEb0 = r_e.result_src[0];
   assign bus.MemWriteM    = r_m_mem_write;
   assign bus.MemSizeM     = r_m_mem_size;
   assign bus.RegWriteM    = r_m_reg_write;
   assign bus.RegWriteW    = r_w_reg_write;
   assign bus.ResultSrcW   = r_w_result_src;
   assign bus.RetireCount  = r_retire;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed scenarios plus randomized traffic checked
// against an instruction-level reference model (two DUTs: full and beq-only branches).
module tb_pipe_controller;
   import alu_ops_pkg::*;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  t_op;
   logic [2:0]  t_f3;
   logic        t_f7, t_valid, t_stall, t_flush;
   logic [31:0] op_a, op_b, w_diff;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   pipe_controller_if #(.CNT_W(CW)) bus ();
   pipe_controller_if #(.CNT_W(CW)) bus_nb ();

   // E-stage flags come from real rs1-rs2 arithmetic on random operands.
   assign w_diff = op_a - op_b;
   assign bus.opD = t_op;         assign bus_nb.opD = t_op;
   assign bus.funct3D = t_f3;     assign bus_nb.funct3D = t_f3;
   assign bus.funct7b5D = t_f7;   assign bus_nb.funct7b5D = t_f7;
   assign bus.ValidD = t_valid;   assign bus_nb.ValidD = t_valid;
   assign bus.StallE = t_stall;   assign bus_nb.StallE = t_stall;
   assign bus.FlushE = t_flush;   assign bus_nb.FlushE = t_flush;
   assign bus.ZeroE = (w_diff == 32'd0);  assign bus_nb.ZeroE = (w_diff == 32'd0);
   assign bus.NegE = w_diff[31];          assign bus_nb.NegE = w_diff[31];
   assign bus.OvfE = (op_a[31] != op_b[31]) && (w_diff[31] != op_a[31]);
   assign bus_nb.OvfE = (op_a[31] != op_b[31]) && (w_diff[31] != op_a[31]);
   assign bus.CarryE = (op_a >= op_b);    assign bus_nb.CarryE = (op_a >= op_b);

   pipe_controller #(.CNT_W(CW), .FULL_BRANCH(1'b1)) u_dut (
      .clk(clk), .reset(reset), .bus(bus));
   pipe_controller #(.CNT_W(CW), .FULL_BRANCH(1'b0)) u_dut_nb (
      .clk(clk), .reset(reset), .bus(bus_nb));

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       jmp;
      logic       jalr;
      logic       br;
      logic [2:0] f3;
      logic [3:0] alu;
      logic       asa;
      logic       asb;
      logic       v;
      logic [2:0] imm;
      logic [2:0] sz;
   } stage_t;

   stage_t      m_e, m_m, m_w;
   int unsigned m_cnt;

   // Instruction-level meaning of each opcode, independent of the RTL encoding.
   function automatic stage_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7, input logic v);
      stage_t d;
      logic [3:0] arith [8];
      arith = '{4'(ALU_ADD), 4'(ALU_SLL), 4'(ALU_SLT), 4'(ALU_SLTU),
                4'(ALU_XOR), 4'(ALU_SRL), 4'(ALU_OR), 4'(ALU_AND)};
      d = '0;
      d.v = v;
      d.f3 = f3;
      d.alu = 4'(ALU_ADD);
      case (op)
         7'b0000011: begin d.rw = 1; d.rs = 2'b01; d.asb = 1; end
         7'b0100011: begin d.mw = 1; d.asb = 1; d.imm = 3'd1; end
         7'b0110011: begin
            d.rw = 1; d.alu = arith[f3];
            if (f3 == 3'd0 && f7) d.alu = 4'(ALU_SUB);
            if (f3 == 3'd5 && f7) d.alu = 4'(ALU_SRA);
         end
         7'b0010011: begin
            d.rw = 1; d.asb = 1; d.alu = arith[f3];
            if (f3 == 3'd5 && f7) d.alu = 4'(ALU_SRA);
         end
         7'b1100011: begin d.br = 1; d.alu = 4'(ALU_SUB); d.imm = 3'd2; end
         7'b1101111: begin d.rw = 1; d.rs = 2'b10; d.jmp = 1; d.imm = 3'd3; end
         7'b1100111: begin d.rw = 1; d.rs = 2'b10; d.asb = 1; d.jmp = 1; d.jalr = 1; end
         7'b0110111: begin d.rw = 1; d.rs = 2'b11; d.imm = 3'd4; end
         7'b0010111: begin d.rw = 1; d.asa = 1; d.asb = 1; d.imm = 3'd4; end
         default: ;
      endcase
      d.rw  = d.rw  & v;
      d.mw  = d.mw  & v;
      d.jmp = d.jmp & v;
      d.br  = d.br  & v;
      return d;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, input logic full);
      if (!full) return a == b;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) <  $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a <  b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_e = '0; m_m = '0; m_w = '0; m_cnt = 0;
   endtask

   task automatic model_step();
      if (m_w.v) m_cnt = (m_cnt + 1) % (1 << CW);
      m_w = m_m;
      if (t_stall) m_m = '0;
      else begin
         m_m = m_e;
         m_m.sz = (m_e.v && (m_e.mw || m_e.rs == 2'b01)) ? m_e.f3 : 3'd0;
      end
      if (t_flush) m_e = '0;
      else if (!t_stall) m_e = ref_decode(t_op, t_f3, t_f7, t_valid);
   endtask

   task automatic check_model();
      stage_t dd;
      dd = ref_decode(t_op, t_f3, t_f7, t_valid);
      chk("imm_src_d", bus.ImmSrcD, dd.imm);
      chk("pcsrc_e", bus.PCSrcE, m_e.jmp | (m_e.br & br_taken(m_e.f3, op_a, op_b, 1'b1)));
      chk("pcsrc_e_nb", bus_nb.PCSrcE, m_e.jmp | (m_e.br & br_taken(m_e.f3, op_a, op_b, 1'b0)));
      chk("jalr_e", bus.JalrE, m_e.jmp & m_e.jalr);
      chk("alu_ctrl_e", bus.ALUControlE, m_e.alu);
      chk("alu_src_a_e", bus.ALUSrcAE, m_e.asa);
      chk("alu_src_b_e", bus.ALUSrcBE, m_e.asb);
      chk("result_src_e_b0", bus.ResultSrcEb0, m_e.rs[0]);
      chk("mem_write_m", bus.MemWriteM, m_m.mw);
      chk("mem_size_m", bus.MemSizeM, m_m.sz);
      chk("reg_write_m", bus.RegWriteM, m_m.rw);
      chk("reg_write_w", bus.RegWriteW, m_w.rw);
      chk("result_src_w", bus.ResultSrcW, m_w.rs);
      chk("retire_count", bus.RetireCount, m_cnt);
      chk("retire_count_nb", bus_nb.RetireCount, m_cnt);
   endtask

   // Inputs are set at posedge+1; outputs are compared at the negedge.
   task automatic tick();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_d(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic v);
      t_op = op; t_f3 = f3; t_f7 = f7; t_valid = v;
   endtask

   task automatic check_regs_zero(input string tag);
      chk({tag, "_pcsrc"}, bus.PCSrcE, 0);
      chk({tag, "_jalr"}, bus.JalrE, 0);
      chk({tag, "_alu"}, bus.ALUControlE, 0);
      chk({tag, "_srca"}, bus.ALUSrcAE, 0);
      chk({tag, "_srcb"}, bus.ALUSrcBE, 0);
      chk({tag, "_eb0"}, bus.ResultSrcEb0, 0);
      chk({tag, "_mw"}, bus.MemWriteM, 0);
      chk({tag, "_sz"}, bus.MemSizeM, 0);
      chk({tag, "_rwm"}, bus.RegWriteM, 0);
      chk({tag, "_rww"}, bus.RegWriteW, 0);
      chk({tag, "_rsw"}, bus.ResultSrcW, 0);
      chk({tag, "_cnt"}, bus.RetireCount, 0);
   endtask

   initial begin
      reset = 1'b0;
      set_d(7'd0, 3'd0, 1'b0, 1'b0);
      t_stall = 1'b0; t_flush = 1'b0;
      op_a = 32'd0; op_b = 32'd0;
      model_reset();
      #12;
      check_regs_zero("rst_init");
      @(posedge clk); #1; reset = 1'b1;

      // Reset asserted mid-cycle with addi's in flight.
      for (int i = 0; i < 5; i++) begin set_d(OP_ITYPE, 3'd0, 1'b0, 1'b1); tick(); end
      #2 reset = 1'b0;
      #1 check_regs_zero("rst_mid");
      model_reset();
      set_d(7'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk); #1; reset = 1'b1;
      chk("rst_cnt_after", bus.RetireCount, 0);

      // Counter wrap: 17 retirements on a 4-bit counter.
      for (int i = 0; i < 17; i++) begin set_d(OP_ITYPE, 3'd0, 1'b0, 1'b1); tick(); end
      set_d(OP_ITYPE, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("wrap_cnt", bus.RetireCount, 1);
      for (int i = 0; i < 4; i++) tick();
      chk("idle_no_incr", bus.RetireCount, 1);

      // Branch conditions.
      set_d(OP_BRANCH, 3'b100, 1'b0, 1'b1); op_a = 32'd1; op_b = 32'd2; tick();
      chk("blt_taken", bus.PCSrcE, 1);
      chk("blt_nb_not_taken", bus_nb.PCSrcE, 0);
      set_d(OP_BRANCH, 3'b110, 1'b0, 1'b1); op_a = 32'd5; op_b = 32'd3; tick();
      chk("bltu_not_taken", bus.PCSrcE, 0);
      set_d(OP_BRANCH, 3'b101, 1'b0, 1'b1); op_a = 32'h7fffffff; op_b = 32'hffffffff; tick();
      chk("bge_taken", bus.PCSrcE, 1);

      // jalr through the pipe.
      set_d(OP_JALR, 3'd0, 1'b0, 1'b1); tick();
      chk("jalr_pcsrc", bus.PCSrcE, 1);
      chk("jalr_jalre", bus.JalrE, 1);
      set_d(7'd0, 3'd0, 1'b0, 1'b0);
      tick(); tick();
      chk("jalr_rw_w", bus.RegWriteW, 1);
      chk("jalr_rs_w", bus.ResultSrcW, 2'b10);

      // lw held in E by a two-cycle stall.
      set_d(OP_LOAD, 3'b010, 1'b0, 1'b1); tick();
      set_d(OP_ITYPE, 3'd0, 1'b0, 1'b1); t_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_eb0", bus.ResultSrcEb0, 1);
         chk("stall_m_rw", bus.RegWriteM, 0);
         chk("stall_m_sz", bus.MemSizeM, 0);
      end
      t_stall = 1'b0; tick();
      chk("lw_m_size", bus.MemSizeM, 3'b010);
      chk("lw_m_rw", bus.RegWriteM, 1);
      chk("addi_e_eb0", bus.ResultSrcEb0, 0);

      // Flush beats stall; the flushed jal never writes back.
      set_d(7'd0, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      set_d(OP_JAL, 3'd0, 1'b0, 1'b1); tick();
      chk("jal_pcsrc", bus.PCSrcE, 1);
      set_d(7'd0, 3'd0, 1'b0, 1'b0); t_flush = 1'b1; t_stall = 1'b1; tick();
      chk("flush_pcsrc", bus.PCSrcE, 0);
      chk("flush_eb0", bus.ResultSrcEb0, 0);
      t_flush = 1'b0; t_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); chk("flushed_rw_w", bus.RegWriteW, 0); end

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0: t_op = OP_LOAD;   1: t_op = OP_STORE;  2: t_op = OP_RTYPE;
            3: t_op = OP_ITYPE;  4: t_op = OP_BRANCH; 5: t_op = OP_BRANCH;
            6: t_op = OP_JAL;    7: t_op = OP_JALR;
            8: t_op = ($urandom_range(0, 1) == 1) ? OP_LUI : OP_AUIPC;
            default: t_op = 7'(($urandom_range(0, 1) == 1) ? 7'b1111111 : 7'b0001011);
         endcase
         t_f3 = 3'($urandom_range(0, 7));
         t_f7 = 1'($urandom_range(0, 1));
         t_valid = ($urandom_range(0, 9) < 8);
         t_stall = ($urandom_range(0, 9) < 2);
         t_flush = ($urandom_range(0, 9) == 0);
         op_a = $urandom;
         op_b = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
         tick();
      end
      set_d(7'd0, 3'd0, 1'b0, 1'b0); t_stall = 1'b0; t_flush = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
